// File: rtl/cipher_pkg.sv
// Shared definitions for the cipher message sequencer: FSM states,
// cipher method codes, direction encodings and the nibble width.
package cipher_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] MTH_RAW    = 2'b00;
    localparam logic [1:0] MTH_CAESAR = 2'b01;
    localparam logic [1:0] MTH_B      = 2'b10;
    localparam logic [1:0] MTH_FREE   = 2'b11;

    localparam logic DIR_DECODE = 1'b0;
    localparam logic DIR_ENCODE = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_V_ISSUE,
        S_V_WAIT,
        S_CHECK,
        S_DONE
    } cipher_state_t;

endpackage

// File: rtl/cipher_seq_btn_sync.sv
// Go-button conditioner: two-flop synchronizer on the raw active-low
// button followed by a falling-edge detector. All flops reset to 1 so a
// released button never produces a spurious edge out of reset.
module cipher_seq_btn_sync
    import cipher_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic go_n,
    output logic go_fall
);

    logic sync_a;
    logic sync_b;
    logic sync_prev;

    // Synchronize the button and keep one cycle of history for edge detection.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_a    <= 1'b1;
            sync_b    <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync_a    <= go_n;
            sync_b    <= sync_a;
            sync_prev <= sync_b;
        end
    end

    assign go_fall = sync_prev & ~sync_b;

endmodule

// File: rtl/cipher_seq_ctrl.sv
// Message-level sequencer for the cipher datapath. Buffers nibbles loaded
// from switches, streams each one through the datapath, writes the result
// back in place and optionally re-runs it in the inverse direction to
// verify it against the original.
// Optional build macro: CIPHER_SEQ_ERRCNT_EN enables the per-run mismatch
// counter on err_count; without it err_count is tied to zero.
module cipher_seq_ctrl
    import cipher_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int CIPHER_LAT = 1
)
(
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NIBBLE_W-1:0]          data_in,
    input  logic                         load,
    input  logic                         go_n,
    input  logic                         decode,
    input  logic [1:0]                   cipher_method,
    input  logic                         verify,
    output logic [NIBBLE_W-1:0]          cph_data,
    output logic                         cph_decode,
    output logic [1:0]                   cph_method,
    input  logic [NIBBLE_W-1:0]          cph_result,
    input  logic [$clog2(DEPTH)-1:0]     rd_idx,
    output logic [NIBBLE_W-1:0]          rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   msg_len,
    output logic                         busy,
    output logic                         done,
    output logic                         verify_pass,
    output logic                         verify_fail,
    output logic [$clog2(DEPTH+1)-1:0]   err_count
);

    localparam int IW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int CW = 3;

    cipher_state_t state;
    cipher_state_t state_nxt;

    logic [NIBBLE_W-1:0] buf_mem [DEPTH];
    logic                buf_we;
    logic [IW-1:0]       buf_waddr;
    logic [NIBBLE_W-1:0] buf_wdata;

    logic [IW-1:0]       idx;
    logic [CW-1:0]       wait_cnt;
    logic                dec_lat;
    logic [1:0]          mth_lat;
    logic                ver_lat;
    logic [NIBBLE_W-1:0] orig_reg;

    logic go_fall;
    logic full;
    logic last_entry;
    logic load_ok;
    logic run_start;
    logic mismatch;

    cipher_seq_btn_sync u_btn_sync (
        .clk     (clk),
        .resetn  (resetn),
        .go_n    (go_n),
        .go_fall (go_fall)
    );

    assign full       = (msg_len == LW'(DEPTH));
    assign last_entry = ((LW'(idx) + LW'(1)) == msg_len);
    assign load_ok    = (state == S_IDLE) && load && !full;
    assign run_start  = (state == S_IDLE) && go_fall && !load && (msg_len != '0);
    assign mismatch   = (cph_result != orig_reg);
    assign rd_data    = buf_mem[rd_idx];

    // State register; reset aborts any run straight back to IDLE.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus busy/done; a load in the same cycle swallows a go edge,
    // and an empty-buffer go just passes through DONE to give its done pulse.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (go_fall && !load) begin
                    state_nxt = (msg_len == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy      = 1'b1;
                state_nxt = (CIPHER_LAT == 0) ? S_CAPTURE : S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (wait_cnt == CW'(1)) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                busy = 1'b1;
                if (ver_lat) begin
                    state_nxt = S_V_ISSUE;
                end else begin
                    state_nxt = last_entry ? S_DONE : S_ISSUE;
                end
            end
            S_V_ISSUE: begin
                busy      = 1'b1;
                state_nxt = (CIPHER_LAT == 0) ? S_CHECK : S_V_WAIT;
            end
            S_V_WAIT: begin
                busy = 1'b1;
                if (wait_cnt == CW'(1)) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                busy      = 1'b1;
                state_nxt = last_entry ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Steer the single buffer write port between switch loads and captured results.
    always_comb begin
        buf_we    = 1'b0;
        buf_waddr = idx;
        buf_wdata = cph_result;
        if (resetn) begin
            if (load_ok) begin
                buf_we    = 1'b1;
                buf_waddr = IW'(msg_len);
                buf_wdata = data_in;
            end else if (state == S_CAPTURE) begin
                buf_we = 1'b1;
            end
        end
    end

    // Message buffer storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[buf_waddr] <= buf_wdata;
        end
    end

    // Run bookkeeping, datapath drive and the sticky verify flags.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            msg_len     <= '0;
            idx         <= '0;
            wait_cnt    <= '0;
            dec_lat     <= DIR_DECODE;
            mth_lat     <= MTH_RAW;
            ver_lat     <= 1'b0;
            orig_reg    <= '0;
            cph_data    <= '0;
            cph_decode  <= DIR_DECODE;
            cph_method  <= MTH_RAW;
            verify_pass <= 1'b0;
            verify_fail <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_ok) begin
                        msg_len <= msg_len + LW'(1);
                    end
                    if (run_start) begin
                        dec_lat     <= decode;
                        mth_lat     <= cipher_method;
                        ver_lat     <= verify;
                        idx         <= '0;
                        verify_pass <= 1'b0;
                        verify_fail <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    cph_data   <= buf_mem[idx];
                    cph_decode <= dec_lat;
                    cph_method <= mth_lat;
                    wait_cnt   <= CW'(CIPHER_LAT);
                end
                S_WAIT, S_V_WAIT: begin
                    wait_cnt <= wait_cnt - CW'(1);
                end
                S_CAPTURE: begin
                    orig_reg <= buf_mem[idx];
                    if (!ver_lat) begin
                        idx <= idx + IW'(1);
                    end
                end
                S_V_ISSUE: begin
                    cph_data   <= buf_mem[idx];
                    cph_decode <= (dec_lat == DIR_ENCODE) ? DIR_DECODE : DIR_ENCODE;
                    cph_method <= mth_lat;
                    wait_cnt   <= CW'(CIPHER_LAT);
                end
                S_CHECK: begin
                    if (mismatch) begin
                        verify_fail <= 1'b1;
                    end
                    idx <= idx + IW'(1);
                end
                S_DONE: begin
                    if (ver_lat && !verify_fail) begin
                        verify_pass <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CIPHER_SEQ_ERRCNT_EN
    // Per-run mismatch counter, cleared at run start and saturating at DEPTH.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_count <= '0;
        end else if (run_start) begin
            err_count <= '0;
        end else if ((state == S_CHECK) && mismatch && (err_count != LW'(DEPTH))) begin
            err_count <= err_count + LW'(1);
        end
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_cipher_seq_ctrl.sv
// Self-checking bench for cipher_seq_ctrl. Three instances (CIPHER_LAT of
// 1, 0 and 3) share the stimulus; each has its own Caesar datapath model.
// Expected run results are queued when a go is issued and a monitor pops
// and compares them on every done pulse.
// Honours CIPHER_SEQ_ERRCNT_EN for the expected err_count.
module tb_cipher_seq_ctrl;
    import cipher_pkg::*;

    localparam int DEPTH = 8;
    localparam int NDUT  = 3;
    localparam int IW    = $clog2(DEPTH);
    localparam int LW    = $clog2(DEPTH+1);

`ifdef CIPHER_SEQ_ERRCNT_EN
    localparam int EC1 = 1;
`else
    localparam int EC1 = 0;
`endif

    typedef struct {
        int   busy_len;
        logic vp;
        logic vf;
        int   ec;
    } exp_t;

    int lat_tab [NDUT] = '{1, 0, 3};

    logic          clk = 1'b0;
    logic          resetn;
    logic [3:0]    data_in;
    logic          load;
    logic          go_n;
    logic          decode;
    logic [1:0]    method;
    logic          verify;
    logic [IW-1:0] rd_idx;
    logic          brk;

    logic [3:0]    rd_data     [NDUT];
    logic [LW-1:0] msg_len     [NDUT];
    logic [LW-1:0] err_count   [NDUT];
    logic          busy        [NDUT];
    logic          done        [NDUT];
    logic          verify_pass [NDUT];
    logic          verify_fail [NDUT];

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q  [NDUT][$];
    logic chk_en [NDUT];
    int   bcnt   [NDUT];
    logic pend   [NDUT];
    exp_t pend_e [NDUT];

    always #5 clk = ~clk;

    // Datapath model: Caesar +3 encode / -3 decode; brk corrupts decode of 5.
    function automatic logic [3:0] cfun(input logic [3:0] d, input logic dir,
                                        input logic [1:0] mth, input logic b);
        if (mth == MTH_RAW) return d;
        if (dir == DIR_ENCODE) return d + 4'd3;
        if (b && d == 4'h5) return d + 4'd4;
        return d - 4'd3;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        logic [3:0] dat;
        logic       dec;
        logic [1:0] mth;
        logic [3:0] res;

        cipher_seq_ctrl #(.DEPTH(DEPTH), .CIPHER_LAT(L)) u_dut (
            .clk           (clk),
            .resetn        (resetn),
            .data_in       (data_in),
            .load          (load),
            .go_n          (go_n),
            .decode        (decode),
            .cipher_method (method),
            .verify        (verify),
            .cph_data      (dat),
            .cph_decode    (dec),
            .cph_method    (mth),
            .cph_result    (res),
            .rd_idx        (rd_idx),
            .rd_data       (rd_data[g]),
            .msg_len       (msg_len[g]),
            .busy          (busy[g]),
            .done          (done[g]),
            .verify_pass   (verify_pass[g]),
            .verify_fail   (verify_fail[g]),
            .err_count     (err_count[g])
        );

        if (L == 0) begin : g_comb
            assign res = cfun(dat, dec, mth, brk);
        end else begin : g_pipe
            logic [3:0] pipe [L];
            always @(posedge clk) begin
                pipe[0] <= cfun(dat, dec, mth, brk);
                for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
            end
            assign res = pipe[L-1];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] nib);
        data_in = nib;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    // Press go; with_load lines a load strobe up with the synchronized edge.
    task automatic pressGo(input logic with_load, input logic [3:0] nib);
        go_n = 1'b0;
        repeat (2) @(negedge clk);
        if (with_load) begin
            data_in = nib;
            load    = 1'b1;
        end
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        go_n = 1'b1;
    endtask

    task automatic doReset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    function automatic int pendingRuns();
        int n = 0;
        for (int g = 0; g < NDUT; g++)
            if (chk_en[g]) n += exp_q[g].size() + (pend[g] ? 1 : 0);
        return n;
    endfunction

    task automatic waitRuns();
        int c = 0;
        while (c < 3000 && pendingRuns() != 0) begin
            @(negedge clk);
            c++;
        end
        checkOutput("run_timeout_pending", pendingRuns(), 0);
        for (int g = 0; g < NDUT; g++) begin
            exp_q[g].delete();
            pend[g] = 1'b0;
        end
    endtask

    task automatic checkEntry(input int g, input int i, input logic [3:0] req);
        rd_idx = IW'(i);
        #1;
        checkOutput($sformatf("buf%0d[%0d]", g, i), rd_data[g], req);
    endtask

    // Monitor: on each done pulse pop the expected run and compare.
    initial begin
        exp_t e;
        for (int g = 0; g < NDUT; g++) begin
            bcnt[g] = 0;
            pend[g] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < NDUT; g++) begin
                if (resetn !== 1'b1) begin
                    bcnt[g] = 0;
                    pend[g] = 1'b0;
                end else begin
                    if (pend[g]) begin
                        checkOutput($sformatf("verify_pass%0d", g), verify_pass[g], pend_e[g].vp);
                        checkOutput($sformatf("verify_fail%0d", g), verify_fail[g], pend_e[g].vf);
                        checkOutput($sformatf("err_count%0d", g), err_count[g], pend_e[g].ec);
                        pend[g] = 1'b0;
                    end
                    if (busy[g] === 1'b1) bcnt[g]++;
                    if (done[g] === 1'b1) begin
                        if (chk_en[g]) begin
                            if (exp_q[g].size() == 0) begin
                                checkOutput($sformatf("unexpected_done%0d", g), 1, 0);
                            end else begin
                                e = exp_q[g].pop_front();
                                checkOutput($sformatf("busy_len%0d", g), bcnt[g], e.busy_len);
                                pend_e[g] = e;
                                pend[g]   = 1'b1;
                            end
                        end
                        bcnt[g] = 0;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   seen_busy;
        logic found;
        resetn  = 1'b0;
        load    = 1'b0;
        go_n    = 1'b1;
        data_in = '0;
        decode  = DIR_DECODE;
        method  = MTH_RAW;
        verify  = 1'b0;
        rd_idx  = '0;
        brk     = 1'b0;
        chk_en  = '{1'b1, 1'b0, 1'b0};
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("rst_msg_len", msg_len[0], 0);
        checkOutput("rst_busy", busy[0], 0);
        checkOutput("rst_done", done[0], 0);
        checkOutput("rst_vpass", verify_pass[0], 0);
        checkOutput("rst_vfail", verify_fail[0], 0);
        checkOutput("rst_errcnt", err_count[0], 0);
        resetn = 1'b1;
        @(negedge clk);

        // Caesar encode of 3,A,F without verify
        $display("[TB] encode 3,A,F");
        applyStimulus(4'h3); applyStimulus(4'hA); applyStimulus(4'hF);
        checkOutput("msg_len_3", msg_len[0], 3);
        decode = DIR_ENCODE; method = MTH_CAESAR; verify = 1'b0;
        exp_q[0].push_back('{9, 1'b0, 1'b0, 0});
        pressGo(1'b0, 4'h0);
        waitRuns();
        checkEntry(0, 0, 4'h6); checkEntry(0, 1, 4'hD); checkEntry(0, 2, 4'h2);

        // Decode in place with verify
        $display("[TB] decode with verify");
        decode = DIR_DECODE; verify = 1'b1;
        exp_q[0].push_back('{18, 1'b1, 1'b0, 0});
        pressGo(1'b0, 4'h0);
        waitRuns();
        checkEntry(0, 0, 4'h3); checkEntry(0, 1, 4'hA); checkEntry(0, 2, 4'hF);

        // Broken inverse on entry 1
        $display("[TB] verify with broken datapath");
        doReset();
        applyStimulus(4'h1); applyStimulus(4'h2); applyStimulus(4'h3);
        brk = 1'b1; decode = DIR_ENCODE; verify = 1'b1;
        exp_q[0].push_back('{18, 1'b0, 1'b1, EC1});
        pressGo(1'b0, 4'h0);
        waitRuns();
        brk = 1'b0;
        checkEntry(0, 0, 4'h4); checkEntry(0, 1, 4'h5); checkEntry(0, 2, 4'h6);

        // Overfill, then go on an empty buffer
        $display("[TB] overfill and empty go");
        doReset();
        for (int i = 0; i < DEPTH + 2; i++) applyStimulus(4'(i));
        checkOutput("msg_len_full", msg_len[0], DEPTH);
        checkEntry(0, 0, 4'h0); checkEntry(0, 7, 4'h7);
        doReset();
        exp_q[0].push_back('{0, 1'b0, 1'b0, 0});
        pressGo(1'b0, 4'h0);
        waitRuns();
        checkOutput("empty_msg_len", msg_len[0], 0);

        // Reset during WAIT of entry 2
        $display("[TB] reset mid-run");
        doReset();
        applyStimulus(4'h1); applyStimulus(4'h2); applyStimulus(4'h3);
        decode = DIR_ENCODE; verify = 1'b0;
        pressGo(1'b0, 4'h0);
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (g_dut[0].u_dut.state == S_WAIT && g_dut[0].u_dut.idx == 3'd2) found = 1'b1;
            else @(negedge clk);
        end
        checkOutput("reach_wait2", found, 1);
        resetn = 1'b0;
        @(negedge clk);
        checkOutput("midrst_state", 32'(g_dut[0].u_dut.state), 32'(S_IDLE));
        checkOutput("midrst_msg_len", msg_len[0], 0);
        checkOutput("midrst_busy", busy[0], 0);
        checkOutput("midrst_done", done[0], 0);
        resetn = 1'b1;
        repeat (10) @(negedge clk);

        // Go edge coinciding with a load: load wins
        $display("[TB] go plus load");
        applyStimulus(4'h7);
        pressGo(1'b1, 4'h5);
        seen_busy = 0;
        for (int c = 0; c < 10; c++) begin
            if (busy[0] === 1'b1) seen_busy++;
            @(negedge clk);
        end
        checkOutput("goload_busy", seen_busy, 0);
        checkOutput("goload_msg_len", msg_len[0], 2);
        checkEntry(0, 1, 4'h5);

        // Latency sweep across all three instances
        $display("[TB] latency sweep");
        doReset();
        chk_en = '{1'b1, 1'b1, 1'b1};
        applyStimulus(4'h3); applyStimulus(4'hA); applyStimulus(4'hF); applyStimulus(4'h1);
        decode = DIR_ENCODE; verify = 1'b0;
        for (int g = 0; g < NDUT; g++) exp_q[g].push_back('{4 * (2 + lat_tab[g]), 1'b0, 1'b0, 0});
        pressGo(1'b0, 4'h0);
        waitRuns();
        for (int g = 0; g < NDUT; g++) begin
            checkEntry(g, 0, 4'h6); checkEntry(g, 1, 4'hD);
            checkEntry(g, 2, 4'h2); checkEntry(g, 3, 4'h4);
        end
        verify = 1'b1;
        for (int g = 0; g < NDUT; g++) exp_q[g].push_back('{8 * (2 + lat_tab[g]), 1'b1, 1'b0, 0});
        pressGo(1'b0, 4'h0);
        waitRuns();
        for (int g = 0; g < NDUT; g++) begin
            checkEntry(g, 0, 4'h9); checkEntry(g, 1, 4'h0);
            checkEntry(g, 2, 4'h5); checkEntry(g, 3, 4'h7);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
